// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register numbers,
// exception codes and the bit positions of the SR and Cause fields.
// No logic lives here.
package cp0_pkg;

    // CP0 register numbers as seen by mtc0/mfc0
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // SR fields
    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LSB = 8;

    // Cause fields
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_BD      = 31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, writable Compare, sticky match pending.
// Latency: pending sets on the edge where Count steps onto Compare; a Compare write clears it on the next edge.
// Backpressure: none; Count advances every cycle unconditionally.
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_compare,
    input  logic [31:0] wr_dat,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        tmr_pend
);

    logic [31:0] count_nxt;

    // Natural 32-bit wrap from FFFF_FFFF to 0
    assign count_nxt = count + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            compare  <= '0;
            tmr_pend <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_compare) begin
                compare  <= wr_dat;
                tmr_pend <= 1'b0;
            end else if ((count_nxt == compare) && (compare != 32'd0)) begin
                // Compare of zero means "timer disarmed"
                tmr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/PRId/Count/Compare, interrupt and exception arbitration.
// Latency: req/int_resp/cp0_out/epc_out are combinational; mtc0 and exception state update on the next edge.
// Backpressure: none; req is a single-cycle request, and an mtc0 coinciding with req is dropped.
// Ports: clk/reset (async active-low); we/cp0_addr/cp0_in mtc0, cp0_out mfc0; vpc/bd_in/exc_code_in
// describe the M instruction; hw_int external lines; exl_clr is eret; epc_out, req, int_resp outputs.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter int          INT_MODE  = 0,
    parameter logic [31:0] PRID      = 32'h0000_4B50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_in,
    output logic [31:0]          cp0_out,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exl_clr,
    output logic [31:0]          epc_out,
    output logic                 req,
    output logic                 int_resp
);

    // IP/IM carry one extra bit above the external lines for the timer
    localparam int NIP = NUM_HWINT + 1;

    logic [NIP-1:0]       im;
    logic [NIP-1:0]       ip;
    logic [NUM_HWINT-1:0] ip_hw;
    logic                 exl, ie, bd;
    logic [4:0]           exc_code;
    logic [31:0]          epc;
    logic [31:0]          epc_raw;
    logic [31:0]          count, compare;
    logic                 tmr_pend;
    logic                 int_req, exc_req;
    logic                 wr_ok, wr_sr, wr_epc, wr_compare;

    assign ip = {tmr_pend, ip_hw};

    assign int_req  = ie & |(ip & im);
    assign exc_req  = (exc_code_in != 5'd0);
    // Gated with reset so the outputs drop the instant reset asserts,
    // even while exc_code_in is still non-zero.
    assign req      = reset & ~exl & (int_req | exc_req);
    assign int_resp = reset & ~exl & int_req;

    // An instruction that traps does not retire its mtc0
    assign wr_ok      = we & ~req;
    assign wr_sr      = wr_ok & (cp0_addr == REG_SR);
    assign wr_epc     = wr_ok & (cp0_addr == REG_EPC);
    assign wr_compare = wr_ok & (cp0_addr == REG_COMPARE);

    assign epc_raw = bd_in ? (vpc - 32'd4) : vpc;
    assign epc_out = (we && (cp0_addr == REG_EPC)) ? cp0_in : epc;

    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .wr_compare (wr_compare),
        .wr_dat     (cp0_in),
        .count      (count),
        .compare    (compare),
        .tmr_pend   (tmr_pend)
    );

    generate
        if (INT_MODE == 1) begin : g_edge
            logic [NUM_HWINT-1:0] hw_prev;
            logic [NUM_HWINT-1:0] clr_mask;
            logic                 wr_cause;

            assign wr_cause = wr_ok & (cp0_addr == REG_CAUSE);
            assign clr_mask = wr_cause ? ~cp0_in[CAUSE_IP_LSB +: NUM_HWINT] : '0;

            // Clear is applied first so a coincident rising edge wins
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hw_prev <= '0;
                    ip_hw   <= '0;
                end else begin
                    hw_prev <= hw_int;
                    ip_hw   <= (ip_hw & ~clr_mask) | (hw_int & ~hw_prev);
                end
            end
        end else begin : g_level
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ip_hw <= '0;
                end else begin
                    ip_hw <= hw_int;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
        end else if (req) begin
            exl      <= 1'b1;
            bd       <= bd_in;
            epc      <= {epc_raw[31:2], 2'b00};
            exc_code <= int_req ? EXC_INT : exc_code_in;
        end else begin
            if (wr_sr) begin
                im  <= cp0_in[SR_IM_LSB +: NIP];
                exl <= cp0_in[SR_EXL];
                ie  <= cp0_in[SR_IE];
            end
            if (exl_clr) begin
                exl <= 1'b0;
            end
            if (wr_epc) begin
                epc <= {cp0_in[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        cp0_out = '0;
        case (cp0_addr)
            REG_SR: begin
                cp0_out[SR_IM_LSB +: NIP] = im;
                cp0_out[SR_EXL]           = exl;
                cp0_out[SR_IE]            = ie;
            end
            REG_CAUSE: begin
                cp0_out[CAUSE_BD]              = bd;
                cp0_out[CAUSE_IP_LSB +: NIP]   = ip;
                cp0_out[CAUSE_EXC_LSB +: 5]    = exc_code;
            end
            REG_EPC:     cp0_out = epc;
            REG_PRID:    cp0_out = PRID;
            REG_COUNT:   cp0_out = count;
            REG_COMPARE: cp0_out = compare;
            default:     cp0_out = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: a level-mode and an edge-mode instance share stimulus.
// Each cycle's expected outputs are queued as it is driven and checked at the falling edge.
// Hand sequences cover the timer and asynchronous reset mid-interrupt.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;

    logic [31:0] out_l, epc_l, out_e, epc_e;
    logic        req_l, resp_l, req_e, resp_e;

    always #5 clk = ~clk;

    cp0_unit #(.NUM_HWINT(6), .INT_MODE(0), .PRID(32'h0000_4B50)) u_lvl (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(out_l), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_l), .req(req_l), .int_resp(resp_l)
    );

    cp0_unit #(.NUM_HWINT(6), .INT_MODE(1), .PRID(32'h0000_4B50)) u_edge (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(out_e), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_e), .req(req_e), .int_resp(resp_e)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eclr;
        int          dut;      // 0 = level instance, 1 = edge instance
        logic        req;
        logic        resp;
        logic [31:0] out;
        logic [31:0] epc;
        logic        alt;      // also check level instance cp0_out
        logic [31:0] alt_out;
    } vec_t;

    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] pc, input logic b, input logic [4:0] ec,
                                input logic [5:0] h, input logic ecl, input int dsel,
                                input logic rq, input logic rs, input logic [31:0] o,
                                input logic [31:0] ep);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.vpc = pc; v.bd = b; v.exc = ec; v.hw = h;
        v.eclr = ecl; v.dut = dsel; v.req = rq; v.resp = rs; v.out = o; v.epc = ep;
        v.alt = 1'b0; v.alt_out = '0;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    endtask

    task automatic drive_idle();
        we = 1'b0; cp0_addr = '0; cp0_in = '0; vpc = '0; bd_in = 1'b0;
        exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
    endtask

    // Drive one cycle, queue its expectation, check at the falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        we = v.we; cp0_addr = v.addr; cp0_in = v.din; vpc = v.vpc; bd_in = v.bd;
        exc_code_in = v.exc; hw_int = v.hw; exl_clr = v.eclr;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.dut == 0) begin
            chk("req",      step_no, {31'b0, req_l},  {31'b0, e.req});
            chk("int_resp", step_no, {31'b0, resp_l}, {31'b0, e.resp});
            chk("cp0_out",  step_no, out_l, e.out);
            chk("epc_out",  step_no, epc_l, e.epc);
        end else begin
            chk("req_e",      step_no, {31'b0, req_e},  {31'b0, e.req});
            chk("int_resp_e", step_no, {31'b0, resp_e}, {31'b0, e.resp});
            chk("cp0_out_e",  step_no, out_e, e.out);
            chk("epc_out_e",  step_no, epc_e, e.epc);
        end
        if (e.alt) chk("cp0_out_lvl", step_no, out_l, e.alt_out);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    vec_t lvl_tab[19];
    vec_t edge_tab[12];

    initial begin
        // Level mode: exception, interrupt over exception, eret, EPC forwarding/suppression, map
        lvl_tab[0]  = mk(1, 12, 32'h0,    32'h3000, 0, 12, 6'b000111, 0, 0, 1, 0, 32'h0,         32'h0);
        lvl_tab[1]  = mk(0, 13, 32'h0,    32'h3000, 0, 12, 6'b000111, 0, 0, 0, 0, 32'h730,       32'h3000);
        lvl_tab[2]  = mk(0, 12, 32'h0,    32'h3000, 0, 12, 6'b000111, 0, 0, 0, 0, 32'h2,         32'h3000);
        lvl_tab[3]  = mk(1, 12, 32'h401,  32'h3000, 0, 0,  6'b000111, 0, 0, 0, 0, 32'h2,         32'h3000);
        lvl_tab[4]  = mk(0, 12, 32'h0,    32'h3008, 1, 12, 6'b000111, 0, 0, 1, 1, 32'h401,       32'h3000);
        lvl_tab[5]  = mk(0, 13, 32'h0,    32'h3008, 1, 0,  6'b000111, 0, 0, 0, 0, 32'h8000_0700, 32'h3004);
        lvl_tab[6]  = mk(0, 14, 32'h0,    32'h3008, 0, 4,  6'b000000, 1, 0, 0, 0, 32'h3004,      32'h3004);
        lvl_tab[7]  = mk(1, 14, 32'h4000, 32'h3010, 0, 4,  6'b000000, 0, 0, 1, 0, 32'h3004,      32'h4000);
        lvl_tab[8]  = mk(0, 14, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h3010,      32'h3010);
        lvl_tab[9]  = mk(1, 14, 32'h4003, 32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h3010,      32'h4003);
        lvl_tab[10] = mk(0, 14, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h4000,      32'h4000);
        lvl_tab[11] = mk(0, 15, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h4B50,      32'h4000);
        lvl_tab[12] = mk(0, 13, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h10,        32'h4000);
        lvl_tab[13] = mk(0, 3,  32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h0,         32'h4000);
        lvl_tab[14] = mk(1, 15, 32'hFFFF, 32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h4B50,      32'h4000);
        lvl_tab[15] = mk(0, 15, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h4B50,      32'h4000);
        lvl_tab[16] = mk(1, 13, 32'h7F00, 32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h10,        32'h4000);
        lvl_tab[17] = mk(0, 13, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h10,        32'h4000);
        lvl_tab[18] = mk(0, 12, 32'h0,    32'h3010, 0, 0,  6'b000000, 0, 0, 0, 0, 32'h403,       32'h4000);

        // Edge mode: sticky capture while masked, unmask, software clear, set-beats-clear
        edge_tab[0]  = mk(1, 12, 32'h1,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h0,   0);
        edge_tab[1]  = mk(0, 13, 32'h0,   0, 0, 0, 6'b000001, 0, 1, 0, 0, 32'h0,   0);
        edge_tab[2]  = mk(0, 13, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h100, 0);
        edge_tab[3]  = mk(0, 13, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h100, 0);
        edge_tab[3].alt = 1'b1;
        edge_tab[3].alt_out = 32'h0;
        edge_tab[4]  = mk(1, 12, 32'h101, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h1,   0);
        edge_tab[5]  = mk(0, 12, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 1, 1, 32'h101, 0);
        edge_tab[6]  = mk(1, 12, 32'h100, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h103, 0);
        edge_tab[7]  = mk(1, 13, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h100, 0);
        edge_tab[8]  = mk(0, 13, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h0,   0);
        edge_tab[9]  = mk(1, 12, 32'h101, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h100, 0);
        edge_tab[10] = mk(0, 12, 32'h0,   0, 0, 0, 6'b000000, 0, 1, 0, 0, 32'h101, 0);
        edge_tab[11] = mk(1, 13, 32'h0,   0, 0, 0, 6'b000001, 0, 1, 0, 0, 32'h0,   0);

        // Reset state, with a pending exception code to prove req is forced low
        drive_idle();
        reset = 1'b0;
        cp0_addr = 5'd12;
        exc_code_in = 5'd12;
        #2;
        chk("rst_req",      -1, {31'b0, req_l},  32'h0);
        chk("rst_int_resp", -1, {31'b0, resp_l}, 32'h0);
        chk("rst_sr",       -1, out_l, 32'h0);
        chk("rst_epc",      -1, epc_l, 32'h0);
        chk("rst_req_e",    -1, {31'b0, req_e},  32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        foreach (lvl_tab[i]) step(lvl_tab[i]);

        drive_idle();
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        foreach (edge_tab[i]) step(edge_tab[i]);

        // Asynchronous reset while the edge instance is requesting an interrupt
        drive_idle();
        hw_int = 6'b000001;
        cp0_addr = 5'd9;
        #2;
        chk("pre_rst_req_e", -2, {31'b0, req_e}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req_e",  -2, {31'b0, req_e},  32'h0);
        chk("mid_rst_resp_e", -2, {31'b0, resp_e}, 32'h0);
        chk("mid_rst_count_e",-2, out_e, 32'h0);
        chk("mid_rst_epc_e",  -2, epc_e, 32'h0);
        chk("mid_rst_req",    -2, {31'b0, req_l},  32'h0);
        chk("mid_rst_count",  -2, out_l, 32'h0);
        @(posedge clk);
        #2;
        drive_idle();
        reset = 1'b1;

        // Timer: step k sees Count == k after reset release
        for (int k = 0; k < 24; k++) begin
            vec_t v;
            if (k == 3)
                v = mk(1, 12, 32'h4001, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
            else if (k == 5)
                v = mk(1, 11, 32'd20, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
            else if (k == 20)
                v = mk(0, 13, 0, 32'h5000, 0, 0, 0, 0, 0, 1, 1, 32'h4000, 0);
            else if (k == 21)
                v = mk(1, 11, 32'd50, 0, 0, 0, 0, 0, 0, 0, 0, 32'd20, 32'h5000);
            else if (k == 22)
                v = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h5000);
            else if (k == 23)
                v = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4003, 32'h5000);
            else
                v = mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, k, 0);
            step(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 for the pipelined MIPS core. It sits beside the M stage and holds SR, Cause, EPC, PRId and a Count/Compare timer. It arbitrates between hardware interrupts and synchronous exceptions, drives the flush/redirect request and supplies EPC for `eret`. It generalises the fixed 6-line CP0 with:
- a configurable interrupt-line count;
- selectable level/edge interrupt capture;
- an internal timer interrupt.

## Interface
Parameters:
- NUM_HWINT, 6, external interrupt lines; legal range 1..7. The timer interrupt takes IP/IM index NUM_HWINT.
- INT_MODE, 0, interrupt capture mode: 0 = level, 1 = edge (sticky, software-cleared).
- PRID, 32'h0000_4B50, constant read value of PRId.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  mtc0 write enable.
- cp0_addr  in  5  register number for mtc0/mfc0.
- cp0_in  in  32  mtc0 data.
- cp0_out  out  32  mfc0 data, combinational.
- vpc  in  32  PC of the instruction in M.
- bd_in  in  1  M instruction is in a delay slot.
- exc_code_in  in  5  pending exception code of the M instruction; 0 = none.
- hw_int  in  NUM_HWINT  external interrupt lines.
- exl_clr  in  1  `eret` in M.
- epc_out  out  32  EPC with mtc0 forwarding.
- req  out  1  take exception/interrupt this cycle.
- int_resp  out  1  req is caused by an interrupt; acknowledge pulse to the bridge.

## Operation
Register map:
- SR (12): IM in bits [8+NUM_HWINT:8], EXL bit 1, IE bit 0.
- Cause (13): BD bit 31, IP in bits [8+NUM_HWINT:8], ExcCode in bits [6:2]. Only IP bits [8+NUM_HWINT-1:8] are writable, and only when INT_MODE=1.
- EPC (14): bits [1:0] always 0.
- PRId (15): read-only.
- Count (9): read-only to software.
- Compare (11): writable.
- Any other address reads 0. Unimplemented and read-only bits read 0 and ignore writes.

Interrupt capture:
- INT_MODE=0: IP[i] follows hw_int[i], registered each cycle.
- INT_MODE=1: IP[i] is set on a registered rising edge of hw_int[i]. It is cleared only by an mtc0 to Cause writing 0 to that bit. If a set and a clear land in the same cycle, the set wins.

Timer:
- Count increments every cycle and wraps 32'hFFFF_FFFF→0.
- When Count==Compare and Compare≠0, the timer IP bit (index NUM_HWINT) becomes sticky 1.
- Any mtc0 to Compare clears the timer IP bit.

Request logic:
- int_req = IE & |(IP & IM).
- exc_req = (exc_code_in≠0).
- req = ~EXL & (int_req | exc_req).
- int_resp = ~EXL & int_req.
- Interrupt has priority over exception.

On a clk edge with req=1:
- EXL←1.
- BD←bd_in.
- EPC←(bd_in ? vpc−4 : vpc) with bits [1:0] cleared.
- ExcCode←int_req ? 0 : exc_code_in.
- An mtc0 in the same cycle is suppressed.

Other events:
- exl_clr clears EXL unless req is high in the same cycle; req wins.
- epc_out = cp0_in when we & cp0_addr==14, otherwise EPC.

## Timing
- Reset (reset low, async): SR, Cause, EPC, Count, Compare, edge-history register and timer pending all go to 0. req=0 and int_resp=0 are forced while reset is low.
- mtc0 takes effect at the next rising edge; mfc0 of the same register in the same cycle returns the old value.
- A hw_int assertion produces req no earlier than one cycle after the edge on which it is sampled.
- Timer: Compare=N written at cycle t with Count=C. IP sets on the edge where Count transitions to N, then req follows one cycle later if enabled.
- Reset deassertion mid-operation resumes with all registers at 0. There is no partial state.

## Structure
- Package cp0_pkg holds:
  - register numbers (SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11);
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12);
  - SR/Cause bit positions.
- One sub-module, cp0_timer: Count/Compare registers, compare match, sticky pending, clear-on-write.

## Test plan
- After reset, set SR=0, hw_int=6'b000111, exc_code_in=12, vpc=32'h3000 → req=1, int_resp=0. Next edge: Cause.ExcCode=12, EPC=32'h3000, EXL=1, and req drops to 0.
- mtc0 SR=32'h0000_0401 (IM[10], IE), hw_int[2]=1, exc_code_in=12, bd_in=1, vpc=32'h3008 → int_resp=1, ExcCode=0, BD=1, EPC=32'h3004.
- INT_MODE=1: pulse hw_int[0] for 1 cycle with IM masked. Later unmask → req=1. Then clear IP[8] via mtc0 Cause with EXL=0 → req stays 0.
- Compare=20 written with Count=5, SR IM[8+NUM_HWINT]=1, IE=1 → timer IP sets when Count reaches 20 and req follows. Rewriting Compare clears it.
- With EXL=1, assert exl_clr and exc_code_in=4 together → EXL cleared, no req that cycle; req=1 the following cycle. With we & cp0_addr=14 & cp0_in=32'h4000 → epc_out=32'h4000 in the same cycle.
- Assert reset low mid-interrupt with Count=123 → all outputs 0 immediately, no clock edge required.
